uart_rx: RTL and testbench

//  Serial receiver paired with the team's UART transmitter: same frame (1 start, dataWidth data LSB-first,

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_sync.sv | 21 ++
 rtl/uart_rx.sv | 207 ++++++++++++++++++++
 tb/tb_uart_rx.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default baud divisor, parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DONE,
    BREAK
  } rx_state_t;

  localparam int CLK_PER_BIT_DEF = 50;

  function automatic logic even_parity(input logic [31:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input; RESET_VAL sets the idle level.
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {2{RESET_VAL}};
    else        sync_q <= {sync_q[0], d_i};
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 1 start, dataWidth data LSB-first, optional even parity, stopBits stop.
// Optional `UART_RX_OVERRUN_EN adds RXack/RXvalid/overrun handshake with sticky overrun detection.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = CLK_PER_BIT_DEF,
  parameter int dataWidth   = 8,
  parameter int stopBits    = 1,
  parameter int parityBits  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 RXin,
`ifdef UART_RX_OVERRUN_EN
  input  logic                 RXack,
  output logic                 RXvalid,
  output logic                 overrun,
`endif
  output logic [dataWidth-1:0] dataOut,
  output logic                 RXdone,
  output logic                 parityErr,
  output logic                 frameErr,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLK_PER_BIT);
  localparam int IDX_W = (dataWidth > 1) ? $clog2(dataWidth) : 1;

  localparam logic [CNT_W-1:0] HALF_CNT  = CNT_W'(CLK_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(dataWidth - 1);
  localparam logic             LAST_STOP = 1'(stopBits - 1);

  logic rx_s;

  uart_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (RXin),
    .q_o  (rx_s)
  );

  rx_state_t            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [dataWidth-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic [dataWidth-1:0] data_q, data_d;
  logic                 rxdone_q, rxdone_d;
  logic                 perr_out_q, perr_out_d;
  logic                 ferr_out_q, ferr_out_d;
  logic                 busy_q, busy_d;
  logic                 load;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    data_d     = data_q;
    rxdone_d   = 1'b0;
    perr_out_d = perr_out_q;
    ferr_out_d = ferr_out_q;
    busy_d     = busy_q;
    load       = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d    = START;
          busy_d     = 1'b1;
          bit_idx_d  = '0;
          stop_idx_d = 1'b0;
          perr_d     = 1'b0;
          ferr_d     = 1'b0;
        end
      end
      START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (cnt_q == FULL_CNT) begin
          cnt_d            = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == LAST_BIT) state_d = (parityBits > 0) ? PARITY : STOP;
          else                       bit_idx_d = bit_idx_q + 1'b1;
        end
      end
      PARITY: begin
        if (cnt_q == FULL_CNT) begin
          cnt_d   = '0;
          perr_d  = rx_s ^ even_parity(32'(shift_q));
          state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == FULL_CNT) begin
          cnt_d = '0;
          if (!rx_s) ferr_d = 1'b1;
          if (stop_idx_q == LAST_STOP) begin
            state_d = DONE;
            load    = 1'b1;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      // Outputs were loaded on entry, so RXdone and the new word are visible together here.
      DONE:    state_d = ferr_q ? BREAK : IDLE;
      BREAK:   if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (load) begin
      data_d     = shift_q;
      perr_out_d = perr_q;
      ferr_out_d = ferr_d;
      rxdone_d   = 1'b1;
      busy_d     = 1'b0;
    end
  end

  // NOTE: the shift register is reset too; it is small and a defined value simplifies debug.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      data_q     <= '0;
      rxdone_q   <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      data_q     <= data_d;
      rxdone_q   <= rxdone_d;
      perr_out_q <= perr_out_d;
      ferr_out_q <= ferr_out_d;
      busy_q     <= busy_d;
    end
  end

  assign dataOut   = data_q;
  assign RXdone    = rxdone_q;
  assign parityErr = perr_out_q;
  assign frameErr  = ferr_out_q;
  assign busy      = busy_q;

`ifdef UART_RX_OVERRUN_EN
  logic rxvalid_q, rxvalid_d;
  logic overrun_q, overrun_d;

  // An ack in the same cycle as a new word consumes the old one, so no overrun is flagged.
  always_comb begin
    rxvalid_d = rxvalid_q;
    overrun_d = overrun_q;
    if (load) begin
      rxvalid_d = 1'b1;
      if (rxvalid_q && !RXack) overrun_d = 1'b1;
      else if (RXack)          overrun_d = 1'b0;
    end else if (RXack) begin
      rxvalid_d = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxvalid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      rxvalid_q <= rxvalid_d;
      overrun_q <= overrun_d;
    end
  end

  assign RXvalid = rxvalid_q;
  assign overrun = overrun_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames push expected words, a monitor checks each RXdone.
module tb_uart_rx;

  localparam int CPB = 50;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       RXin = 1'b1;
  logic [7:0] dataOut;
  logic       RXdone, parityErr, frameErr, busy;
`ifdef UART_RX_OVERRUN_EN
  logic       RXack = 1'b0;
  logic       RXvalid, overrun;
`endif

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_done   = 0;

  uart_rx #(.CLK_PER_BIT(CPB), .dataWidth(8), .stopBits(1), .parityBits(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .RXin     (RXin),
`ifdef UART_RX_OVERRUN_EN
    .RXack    (RXack),
    .RXvalid  (RXvalid),
    .overrun  (overrun),
`endif
    .dataOut  (dataOut),
    .RXdone   (RXdone),
    .parityErr(parityErr),
    .frameErr (frameErr),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    RXin = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(s);
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check({name, "_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: every RXdone must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n && RXdone) begin
      exp_t e;
      n_done++;
      if (exp_q.size() == 0) begin
        check("unexpected_rxdone", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("dataOut",   32'(dataOut),   32'(e.data));
        check("parityErr", 32'(parityErr), 32'(e.perr));
        check("frameErr",  32'(frameErr),  32'(e.ferr));
        check("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  initial begin
    int done_before;
    int busy_seen;

    repeat (3) @(negedge clk);
    check("rst_dataOut", 32'(dataOut), 32'd0);
    check("rst_rxdone",  32'(RXdone),  32'd0);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_flags",   32'({parityErr, frameErr}), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 1: clean frame 0xA5 (four ones, parity 0)
    exp_q.push_back('{data: 8'hA5, perr: 1'b0, ferr: 1'b0});
    send_frame(8'hA5, 1'b0, 1'b1);
    drain("t1");
    check("t1_busy_after", 32'(busy), 32'd0);
    check("t1_done_count", 32'(n_done), 32'd1);

    // 2: 0x01 needs parity 1; send 0
    exp_q.push_back('{data: 8'h01, perr: 1'b1, ferr: 1'b0});
    send_frame(8'h01, 1'b0, 1'b1);
    drain("t2");

    // 3: 0x3C with stop low, then line held low for 20 bit-times
    done_before = n_done;
    exp_q.push_back('{data: 8'h3C, perr: 1'b0, ferr: 1'b1});
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (20 * CPB) @(negedge clk);
    drain("t3");
    check("t3_one_done", 32'(n_done - done_before), 32'd1);
    check("t3_busy_in_break", 32'(busy), 32'd0);
    RXin = 1'b1;
    repeat (4 * CPB) @(negedge clk);
    check("t3_no_rearm", 32'(n_done - done_before), 32'd1);

    // 4: 10-clock glitch on an idle line
    done_before = n_done;
    busy_seen   = 0;
    RXin = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (busy) busy_seen = 1;
    end
    RXin = 1'b1;
    repeat (25) @(negedge clk);
    check("t4_busy_seen", 32'(busy_seen | busy), 32'd1);
    repeat (5) @(negedge clk);
    check("t4_busy_dropped", 32'(busy), 32'd0);
    repeat (2 * CPB) @(negedge clk);
    check("t4_no_done", 32'(n_done - done_before), 32'd0);

`ifdef UART_RX_OVERRUN_EN
    RXack = 1'b1;
    @(negedge clk);
    RXack = 1'b0;
    check("ack_clears_overrun", 32'(overrun), 32'd0);
`endif

    // 5: back-to-back frames, no idle gap
    done_before = n_done;
    exp_q.push_back('{data: 8'h55, perr: 1'b0, ferr: 1'b0});
    exp_q.push_back('{data: 8'hAA, perr: 1'b0, ferr: 1'b0});
    send_frame(8'h55, 1'b0, 1'b1);
    send_frame(8'hAA, 1'b0, 1'b1);
    drain("t5");
    check("t5_two_done", 32'(n_done - done_before), 32'd2);
    check("t5_last_word", 32'(dataOut), 32'hAA);
`ifdef UART_RX_OVERRUN_EN
    check("t5_overrun", 32'(overrun), 32'd1);
    check("t5_rxvalid", 32'(RXvalid), 32'd1);
`endif

    // 6: reset pulsed mid-DATA of 0xFF, then 0x12 (two ones, parity 0)
    send_bit(1'b0);
    repeat (4) send_bit(1'b1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_dataOut", 32'(dataOut), 32'd0);
    check("t6_rst_busy",    32'(busy),    32'd0);
    check("t6_rst_rxdone",  32'(RXdone),  32'd0);
    RXin = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    exp_q.push_back('{data: 8'h12, perr: 1'b0, ferr: 1'b0});
    send_frame(8'h12, 1'b0, 1'b1);
    drain("t6");
    check("t6_busy_after", 32'(busy), 32'd0);

    repeat (10) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
